// File: rtl/lieat_ifu_bpu_pkg.sv
// Shared widths, FSM encoding and return-address-stack depth for the static branch predictor.
package lieat_ifu_bpu_pkg;

    localparam int XLEN       = 32;
    localparam int RGIDX_SIZE = 5;
    localparam int RAS_DEPTH  = 4;

    typedef enum logic {
        ST_IDLE     = 1'b0,
        ST_WAIT_RS1 = 1'b1
    } bpu_state_e;

    function automatic logic is_link_reg(input logic [RGIDX_SIZE-1:0] idx);
        return (idx == RGIDX_SIZE'(1)) || (idx == RGIDX_SIZE'(5));
    endfunction

endpackage

// File: rtl/lieat_ifu_bpu_if.sv
// Decoded-instruction input, regfile read port and registered prediction output of the BPU stage.
interface lieat_ifu_bpu_if;
    import lieat_ifu_bpu_pkg::*;

    logic                  i_valid;
    logic                  i_ready;
    logic [XLEN-1:0]       i_pc;
    logic [XLEN-1:0]       i_inst;
    logic [RGIDX_SIZE-1:0] i_rd;
    logic [RGIDX_SIZE-1:0] i_rs1;
    logic [XLEN-1:0]       i_imm;
    logic                  i_jal;
    logic                  i_jalr;
    logic                  i_bxx;
    logic [RGIDX_SIZE-1:0] rf_rs1_idx;
    logic [XLEN-1:0]       rf_rs1_rdata;
    logic                  rf_rs1_busy;
    logic                  o_valid;
    logic                  o_ready;
    logic [XLEN-1:0]       o_pc;
    logic [XLEN-1:0]       o_inst;
    logic                  o_taken;
    logic [XLEN-1:0]       o_npc;
    logic                  redirect_valid;
    logic [XLEN-1:0]       redirect_pc;

    modport master (
        output i_valid, i_pc, i_inst, i_rd, i_rs1, i_imm, i_jal, i_jalr, i_bxx,
        output rf_rs1_rdata, rf_rs1_busy, o_ready,
        input  i_ready, rf_rs1_idx, o_valid, o_pc, o_inst, o_taken, o_npc,
        input  redirect_valid, redirect_pc
    );

    modport slave (
        input  i_valid, i_pc, i_inst, i_rd, i_rs1, i_imm, i_jal, i_jalr, i_bxx,
        input  rf_rs1_rdata, rf_rs1_busy, o_ready,
        output i_ready, rf_rs1_idx, o_valid, o_pc, o_inst, o_taken, o_npc,
        output redirect_valid, redirect_pc
    );

endinterface

// File: rtl/lieat_ifu_ras.sv
// Circular return-address stack: a push when full overwrites the oldest entry; push+pop replaces the top.
module lieat_ifu_ras
    import lieat_ifu_bpu_pkg::*;
#(
    parameter int DEPTH = RAS_DEPTH
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            push_i,
    input  logic            pop_i,
    input  logic [XLEN-1:0] push_data_i,
    output logic [XLEN-1:0] top_o,
    output logic            empty_o
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [XLEN-1:0] mem_q [DEPTH];
    logic [PW-1:0]   sp_q, sp_d, sp_inc_s, sp_dec_s, wr_idx_s;
    logic [PW:0]     cnt_q, cnt_d;
    logic            wr_en_s;

    assign sp_inc_s = (sp_q == PW'(DEPTH - 1)) ? '0 : sp_q + PW'(1);
    assign sp_dec_s = (sp_q == '0) ? PW'(DEPTH - 1) : sp_q - PW'(1);
    assign top_o    = mem_q[sp_q];
    assign empty_o  = (cnt_q == '0);

    always_comb begin
        sp_d     = sp_q;
        cnt_d    = cnt_q;
        wr_en_s  = 1'b0;
        wr_idx_s = sp_q;
        if (push_i && pop_i) begin
            wr_en_s = 1'b1;
        end else if (push_i) begin
            sp_d     = sp_inc_s;
            wr_idx_s = sp_inc_s;
            wr_en_s  = 1'b1;
            cnt_d    = (cnt_q == (PW+1)'(DEPTH)) ? cnt_q : cnt_q + (PW+1)'(1);
        end else if (pop_i) begin
            sp_d  = sp_dec_s;
            cnt_d = cnt_q - (PW+1)'(1);
        end else begin
            sp_d = sp_q;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            sp_q  <= '0;
            cnt_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            sp_q  <= sp_d;
            cnt_q <= cnt_d;
            if (wr_en_s) begin
                mem_q[wr_idx_s] <= push_data_i;
            end
        end
    end

endmodule

// File: rtl/lieat_ifu_bpu.sv
// Static branch predictor between the IFU pre-decoder and the IFU/IDU register.
// Optional return-address stack enabled by defining LIEAT_BPU_RAS_EN.
module lieat_ifu_bpu
    import lieat_ifu_bpu_pkg::*;
(
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  flush,
    lieat_ifu_bpu_if.slave        bus
);

    bpu_state_e            state_q, state_d;
    logic [XLEN-1:0]       pc_l_q, inst_l_q, imm_l_q;
    logic [RGIDX_SIZE-1:0] rs1_l_q;
    logic                  o_valid_q, o_valid_d, o_taken_q, o_taken_d, redirect_q, redirect_d;
    logic [XLEN-1:0]       o_pc_q, o_pc_d, o_inst_q, o_inst_d, o_npc_q, o_npc_d;

    logic                  i_ready_s, xfer_s, wait_s, done_s, latch_en_s, out_free_s;
    logic                  pred_taken_s, ras_hit_s;
    logic [XLEN-1:0]       pred_npc_s, base_s, pc4_s, br_tgt_s, jalr_sum_s, wait_sum_s, ras_top_s;

    assign out_free_s = ~o_valid_q | bus.o_ready;
    assign i_ready_s  = (state_q == ST_IDLE) & out_free_s & ~flush;
    assign xfer_s     = bus.i_valid & i_ready_s;

`ifdef LIEAT_BPU_RAS_EN
    logic ras_empty_s, ras_push_s, ras_pop_s, rd_link_s, rs1_link_s;

    assign rd_link_s  = is_link_reg(bus.i_rd);
    assign rs1_link_s = is_link_reg(bus.i_rs1);
    // pop on a return (rd=x0) or a coroutine swap (both link regs, rd!=rs1)
    assign ras_hit_s  = bus.i_jalr & rs1_link_s & ~ras_empty_s &
                        ((bus.i_rd == '0) | (rd_link_s & (bus.i_rd != bus.i_rs1)));
    assign ras_pop_s  = xfer_s & ras_hit_s;
    assign ras_push_s = xfer_s & (bus.i_jal | bus.i_jalr) & rd_link_s;

    lieat_ifu_ras #(.DEPTH(RAS_DEPTH)) u_ras (
        .clock       (clock),
        .reset       (reset),
        .push_i      (ras_push_s),
        .pop_i       (ras_pop_s),
        .push_data_i (pc4_s),
        .top_o       (ras_top_s),
        .empty_o     (ras_empty_s)
    );
`else
    logic unused_rd_s;

    assign ras_hit_s   = 1'b0;
    assign ras_top_s   = '0;
    assign unused_rd_s = ^bus.i_rd;
`endif

    assign base_s     = (bus.i_rs1 == '0) ? '0 : bus.rf_rs1_rdata;
    assign pc4_s      = bus.i_pc + XLEN'(4);
    assign br_tgt_s   = bus.i_pc + bus.i_imm;
    assign jalr_sum_s = base_s + bus.i_imm;
    assign wait_sum_s = bus.rf_rs1_rdata + imm_l_q;
    assign wait_s     = bus.i_jalr & ~ras_hit_s & (bus.i_rs1 != '0) & bus.rf_rs1_busy;
    assign done_s     = ~bus.rf_rs1_busy & out_free_s;

    // Prediction for the incoming instruction
    always_comb begin
        pred_taken_s = 1'b0;
        pred_npc_s   = pc4_s;
        if (bus.i_jal) begin
            pred_taken_s = 1'b1;
            pred_npc_s   = br_tgt_s;
        end else if (bus.i_jalr) begin
            pred_taken_s = 1'b1;
            pred_npc_s   = ras_hit_s ? ras_top_s : {jalr_sum_s[XLEN-1:1], 1'b0};
        end else if (bus.i_bxx) begin
            pred_taken_s = bus.i_imm[XLEN-1];
            pred_npc_s   = bus.i_imm[XLEN-1] ? br_tgt_s : pc4_s;
        end else begin
            pred_taken_s = 1'b0;
        end
    end

    // FSM next state and output-register load; flush overrides everything
    always_comb begin
        state_d    = state_q;
        o_valid_d  = o_valid_q;
        o_pc_d     = o_pc_q;
        o_inst_d   = o_inst_q;
        o_taken_d  = o_taken_q;
        o_npc_d    = o_npc_q;
        redirect_d = 1'b0;
        latch_en_s = 1'b0;
        if (flush) begin
            o_valid_d = 1'b0;
            state_d   = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (xfer_s && wait_s) begin
                        latch_en_s = 1'b1;
                        o_valid_d  = 1'b0;
                        state_d    = ST_WAIT_RS1;
                    end else if (xfer_s) begin
                        o_valid_d  = 1'b1;
                        o_pc_d     = bus.i_pc;
                        o_inst_d   = bus.i_inst;
                        o_taken_d  = pred_taken_s;
                        o_npc_d    = pred_npc_s;
                        redirect_d = pred_taken_s;
                    end else if (bus.o_ready) begin
                        o_valid_d = 1'b0;
                    end else begin
                        o_valid_d = o_valid_q;
                    end
                end
                ST_WAIT_RS1: begin
                    if (done_s) begin
                        o_valid_d  = 1'b1;
                        o_pc_d     = pc_l_q;
                        o_inst_d   = inst_l_q;
                        o_taken_d  = 1'b1;
                        o_npc_d    = {wait_sum_s[XLEN-1:1], 1'b0};
                        redirect_d = 1'b1;
                        state_d    = ST_IDLE;
                    end else if (bus.o_ready) begin
                        o_valid_d = 1'b0;
                    end else begin
                        o_valid_d = o_valid_q;
                    end
                end
                default: begin
                    o_valid_d = 1'b0;
                    state_d   = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            o_valid_q  <= 1'b0;
            o_pc_q     <= '0;
            o_inst_q   <= '0;
            o_taken_q  <= 1'b0;
            o_npc_q    <= '0;
            redirect_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            o_valid_q  <= o_valid_d;
            o_pc_q     <= o_pc_d;
            o_inst_q   <= o_inst_d;
            o_taken_q  <= o_taken_d;
            o_npc_q    <= o_npc_d;
            redirect_q <= redirect_d;
        end
    end

    // Held copy of a jalr waiting for its base register
    always_ff @(posedge clock) begin
        if (reset) begin
            pc_l_q   <= '0;
            inst_l_q <= '0;
            imm_l_q  <= '0;
            rs1_l_q  <= '0;
        end else if (latch_en_s) begin
            pc_l_q   <= bus.i_pc;
            inst_l_q <= bus.i_inst;
            imm_l_q  <= bus.i_imm;
            rs1_l_q  <= bus.i_rs1;
        end else begin
            rs1_l_q  <= rs1_l_q;
        end
    end

    assign bus.i_ready        = i_ready_s;
    assign bus.rf_rs1_idx     = (state_q == ST_WAIT_RS1) ? rs1_l_q : bus.i_rs1;
    assign bus.o_valid        = o_valid_q;
    assign bus.o_pc           = o_pc_q;
    assign bus.o_inst         = o_inst_q;
    assign bus.o_taken        = o_taken_q;
    assign bus.o_npc          = o_npc_q;
    assign bus.redirect_valid = redirect_q;
    assign bus.redirect_pc    = o_npc_q;

endmodule

// File: tb/tb_lieat_ifu_bpu.sv
// Directed bench for lieat_ifu_bpu: vector table for single predictions plus stall/flush/backpressure sequences.
module tb_lieat_ifu_bpu;
    import lieat_ifu_bpu_pkg::*;

    logic clock, reset, flush;
    int   total, bad;

    lieat_ifu_bpu_if bus();

    lieat_ifu_bpu dut (
        .clock (clock),
        .reset (reset),
        .flush (flush),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [31:0] pc, inst, imm, rdata;
        logic [4:0]  rs1, rd;
        logic        jal, jalr, bxx, busy, exp_taken;
        logic [31:0] exp_npc;
    } vec_t;

    vec_t vecs [9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic [31:0] pc, input logic [31:0] imm, input logic [4:0] rs1,
                         input logic [4:0] rd, input logic jal, input logic jalr, input logic bxx);
        bus.i_valid = 1'b1;
        bus.i_pc    = pc;
        bus.i_inst  = pc ^ 32'hA5A5_0000;
        bus.i_imm   = imm;
        bus.i_rs1   = rs1;
        bus.i_rd    = rd;
        bus.i_jal   = jal;
        bus.i_jalr  = jalr;
        bus.i_bxx   = bxx;
    endtask

    task automatic idle_in();
        bus.i_valid = 1'b0;
        bus.i_jal   = 1'b0;
        bus.i_jalr  = 1'b0;
        bus.i_bxx   = 1'b0;
        bus.i_rs1   = 5'd0;
        bus.i_rd    = 5'd0;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        reset = 1'b1;
        flush = 1'b0;
        idle_in();
        bus.i_pc         = 32'h0;
        bus.i_inst       = 32'h0;
        bus.i_imm        = 32'h0;
        bus.rf_rs1_rdata = 32'h0;
        bus.rf_rs1_busy  = 1'b0;
        bus.o_ready      = 1'b1;

        //             pc            inst          imm           rdata         rs1   rd    jal   jalr  bxx   busy  tkn   npc
        vecs[0] = '{32'h8000_0010, 32'h0000_0063, 32'hFFFF_FFF0, 32'h0,        5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32'h8000_0000};
        vecs[1] = '{32'h8000_0020, 32'h0000_0163, 32'h0000_0020, 32'h0,        5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h8000_0024};
        vecs[2] = '{32'h0000_1000, 32'h0000_006F, 32'h0000_0100, 32'h0,        5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_1100};
        vecs[3] = '{32'hFFFF_FFF0, 32'h0000_106F, 32'h0000_0020, 32'h0,        5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_0010};
        vecs[4] = '{32'h0000_2000, 32'h0000_0067, 32'h0000_0101, 32'h1234_5678, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 32'h0000_0100};
        vecs[5] = '{32'h0000_2100, 32'h0001_8067, 32'h0000_0003, 32'h0000_2000, 5'd3, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 32'h0000_2002};
        vecs[6] = '{32'h0000_0400, 32'h0000_0013, 32'hFFFF_FFF0, 32'h0,        5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_0404};
        vecs[7] = '{32'h0000_2200, 32'h0003_8067, 32'hFFFF_FFFF, 32'h8000_0100, 5'd7, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 32'h8000_00FE};
        vecs[8] = '{32'h0000_0004, 32'h0000_0263, 32'hFFFF_FFF0, 32'h0,        5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32'hFFFF_FFF4};

        tick();
        tick();
        chk("rst_o_valid", 32'(bus.o_valid), 32'd0);
        chk("rst_o_taken", 32'(bus.o_taken), 32'd0);
        chk("rst_redirect", 32'(bus.redirect_valid), 32'd0);
        chk("rst_o_pc", bus.o_pc, 32'h0);
        chk("rst_o_inst", bus.o_inst, 32'h0);
        chk("rst_o_npc", bus.o_npc, 32'h0);
        chk("rst_redirect_pc", bus.redirect_pc, 32'h0);
        reset = 1'b0;
        #1;
        chk("rst_i_ready", 32'(bus.i_ready), 32'd1);

        for (int i = 0; i < 9; i++) begin
            drive(vecs[i].pc, vecs[i].imm, vecs[i].rs1, vecs[i].rd, vecs[i].jal, vecs[i].jalr, vecs[i].bxx);
            bus.i_inst       = vecs[i].inst;
            bus.rf_rs1_rdata = vecs[i].rdata;
            bus.rf_rs1_busy  = vecs[i].busy;
            #1;
            chk($sformatf("v%0d_i_ready", i), 32'(bus.i_ready), 32'd1);
            tick();
            idle_in();
            bus.rf_rs1_busy = 1'b0;
            chk($sformatf("v%0d_o_valid", i), 32'(bus.o_valid), 32'd1);
            chk($sformatf("v%0d_o_pc", i), bus.o_pc, vecs[i].pc);
            chk($sformatf("v%0d_o_inst", i), bus.o_inst, vecs[i].inst);
            chk($sformatf("v%0d_o_taken", i), 32'(bus.o_taken), 32'(vecs[i].exp_taken));
            chk($sformatf("v%0d_o_npc", i), bus.o_npc, vecs[i].exp_npc);
            chk($sformatf("v%0d_redirect", i), 32'(bus.redirect_valid), 32'(vecs[i].exp_taken));
            chk($sformatf("v%0d_redirect_pc", i), bus.redirect_pc, vecs[i].exp_npc);
            tick();
            chk($sformatf("v%0d_drain_valid", i), 32'(bus.o_valid), 32'd0);
            chk($sformatf("v%0d_drain_redirect", i), 32'(bus.redirect_valid), 32'd0);
        end

        // jalr x5 stalls while x5 is busy, then resolves with fresh rdata
        drive(32'h0000_3000, 32'h0000_0007, 5'd5, 5'd0, 1'b0, 1'b1, 1'b0);
        bus.rf_rs1_busy  = 1'b1;
        bus.rf_rs1_rdata = 32'h0;
        #1;
        chk("stall_accept", 32'(bus.i_ready), 32'd1);
        tick();
        idle_in();
        bus.i_rs1 = 5'd9;
        for (int c = 0; c < 3; c++) begin
            chk($sformatf("stall_c%0d_i_ready", c), 32'(bus.i_ready), 32'd0);
            chk($sformatf("stall_c%0d_o_valid", c), 32'(bus.o_valid), 32'd0);
            chk($sformatf("stall_c%0d_idx", c), 32'(bus.rf_rs1_idx), 32'd5);
            tick();
        end
        bus.rf_rs1_busy  = 1'b0;
        bus.rf_rs1_rdata = 32'h8000_1000;
        #1;
        chk("stall_done_i_ready", 32'(bus.i_ready), 32'd0);
        tick();
        chk("stall_o_valid", 32'(bus.o_valid), 32'd1);
        chk("stall_o_pc", bus.o_pc, 32'h0000_3000);
        chk("stall_o_npc", bus.o_npc, 32'h8000_1006);
        chk("stall_redirect", 32'(bus.redirect_valid), 32'd1);
        chk("stall_redirect_pc", bus.redirect_pc, 32'h8000_1006);
        tick();
        chk("stall_after_i_ready", 32'(bus.i_ready), 32'd1);
        chk("stall_after_redirect", 32'(bus.redirect_valid), 32'd0);

        // backpressure: output must hold, single redirect pulse
        bus.o_ready = 1'b0;
        drive(32'h8000_0010, 32'hFFFF_FFF0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1);
        tick();
        chk("bp_redirect_first", 32'(bus.redirect_valid), 32'd1);
        drive(32'h0000_0500, 32'h0000_0008, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1);
        for (int c = 0; c < 4; c++) begin
            chk($sformatf("bp_c%0d_i_ready", c), 32'(bus.i_ready), 32'd0);
            chk($sformatf("bp_c%0d_o_valid", c), 32'(bus.o_valid), 32'd1);
            chk($sformatf("bp_c%0d_o_pc", c), bus.o_pc, 32'h8000_0010);
            chk($sformatf("bp_c%0d_o_npc", c), bus.o_npc, 32'h8000_0000);
            if (c > 0) chk($sformatf("bp_c%0d_redirect", c), 32'(bus.redirect_valid), 32'd0);
            tick();
        end
        bus.o_ready = 1'b1;
        #1;
        chk("bp_release_i_ready", 32'(bus.i_ready), 32'd1);
        tick();
        idle_in();
        chk("bp_next_o_pc", bus.o_pc, 32'h0000_0500);
        chk("bp_next_o_npc", bus.o_npc, 32'h0000_0504);
        chk("bp_next_taken", 32'(bus.o_taken), 32'd0);
        chk("bp_next_redirect", 32'(bus.redirect_valid), 32'd0);
        tick();

        // flush during WAIT_RS1, in the same cycle the base becomes ready
        drive(32'h0000_6000, 32'h0000_0010, 5'd6, 5'd0, 1'b0, 1'b1, 1'b0);
        bus.rf_rs1_busy = 1'b1;
        tick();
        idle_in();
        bus.rf_rs1_busy  = 1'b0;
        bus.rf_rs1_rdata = 32'h0000_7000;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        #1;
        chk("flw_o_valid", 32'(bus.o_valid), 32'd0);
        chk("flw_redirect", 32'(bus.redirect_valid), 32'd0);
        chk("flw_i_ready", 32'(bus.i_ready), 32'd1);
        tick();
        chk("flw_late_o_valid", 32'(bus.o_valid), 32'd0);

        // flush beats a simultaneous o_ready and a new transfer
        drive(32'h0000_0800, 32'h0000_0040, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0);
        tick();
        chk("flo_loaded", 32'(bus.o_valid), 32'd1);
        drive(32'h0000_0900, 32'h0000_0040, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0);
        flush = 1'b1;
        #1;
        chk("flo_i_ready", 32'(bus.i_ready), 32'd0);
        tick();
        flush = 1'b0;
        idle_in();
        chk("flo_o_valid", 32'(bus.o_valid), 32'd0);
        chk("flo_redirect", 32'(bus.redirect_valid), 32'd0);

        // reset while waiting on rs1
        drive(32'h0000_A000, 32'h0000_0004, 5'd8, 5'd0, 1'b0, 1'b1, 1'b0);
        bus.rf_rs1_busy = 1'b1;
        tick();
        idle_in();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        bus.rf_rs1_busy = 1'b0;
        #1;
        chk("rmw_i_ready", 32'(bus.i_ready), 32'd1);
        tick();
        chk("rmw_o_valid", 32'(bus.o_valid), 32'd0);
        chk("rmw_redirect", 32'(bus.redirect_valid), 32'd0);

`ifdef LIEAT_BPU_RAS_EN
        // call pushes 0x104; return pops it with x1 busy and no stall
        drive(32'h0000_0100, 32'h0000_0040, 5'd0, 5'd1, 1'b1, 1'b0, 1'b0);
        tick();
        chk("ras_call_npc", bus.o_npc, 32'h0000_0140);
        drive(32'h0000_0140, 32'h0000_0000, 5'd1, 5'd0, 1'b0, 1'b1, 1'b0);
        bus.rf_rs1_busy  = 1'b1;
        bus.rf_rs1_rdata = 32'hDEAD_0000;
        #1;
        chk("ras_ret_i_ready", 32'(bus.i_ready), 32'd1);
        tick();
        idle_in();
        bus.rf_rs1_busy = 1'b0;
        chk("ras_ret_o_valid", 32'(bus.o_valid), 32'd1);
        chk("ras_ret_npc", bus.o_npc, 32'h0000_0104);
        chk("ras_ret_redirect", 32'(bus.redirect_valid), 32'd1);
        tick();
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
